// File: rtl/flash_pkg.sv
// Shared definitions for the NOR flash host/device pair: bus op codes,
// Intel command bytes, status register bit positions and emulator modes.
package flash_pkg;

    typedef enum logic [1:0] {
        FLASHOP_IDLE  = 2'd0,
        FLASHOP_READ  = 2'd1,
        FLASHOP_WRITE = 2'd2
    } flash_op_e;

    localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
    localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
    localparam logic [7:0] CMD_PROGRAM      = 8'h40;
    localparam logic [7:0] CMD_PROGRAM_ALT  = 8'h10;
    localparam logic [7:0] CMD_ERASE        = 8'h20;
    localparam logic [7:0] CMD_CONFIRM      = 8'hD0;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;

    localparam logic [7:0] SR_RESET_VALUE = 8'h80;

    // Erase is split into the word-clear sweep and the trailing idle period
    typedef enum logic [2:0] {
        MODE_READ_ARRAY  = 3'd0,
        MODE_READ_STATUS = 3'd1,
        MODE_PROG_SETUP  = 3'd2,
        MODE_PROG_BUSY   = 3'd3,
        MODE_ERASE_SETUP = 3'd4,
        MODE_ERASE_SWEEP = 3'd5,
        MODE_ERASE_TAIL  = 3'd6
    } flash_mode_e;

endpackage

// File: rtl/flash_emu_if.sv
// Control/address side of the parallel NOR flash bus. The data bus is
// bidirectional and stays a plain port on the device.
interface flash_emu_if;

    logic [23:0] flash_address;
    logic        flash_ce_b;
    logic        flash_oe_b;
    logic        flash_we_b;
    logic        flash_reset_b;
    logic        flash_byte_b;
    logic        flash_sts;

    modport master (
        output flash_address, flash_ce_b, flash_oe_b, flash_we_b,
               flash_reset_b, flash_byte_b,
        input  flash_sts
    );

    modport slave (
        input  flash_address, flash_ce_b, flash_oe_b, flash_we_b,
               flash_reset_b, flash_byte_b,
        output flash_sts
    );

endinterface

// File: rtl/flash_emu_ram.sv
// Single-port synchronous-read RAM backing the emulated flash array.
// Contents start erased (all ones) and are never touched by reset.
module flash_emu_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clock,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [15:0]          wdata_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] mem [0:(1<<ADDR_BITS)-1] = '{default: 16'hFFFF};

    // Write-first is irrelevant here: the controller never reads what it writes in the same cycle
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/flash_emu.sv
// StrataFlash-style device emulator: decodes host bus cycles into the
// Intel command set and serves reads from block RAM or the status register.
module flash_emu
    import flash_pkg::*;
#(
    parameter int ADDR_BITS          = 12,
    parameter int BLOCK_BITS         = 6,
    parameter int PROGRAM_CYCLES     = 20,
    parameter int ERASE_EXTRA_CYCLES = 50
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [15:0] flash_data,
    flash_emu_if.slave  bus
);

    localparam int CNT_W = 16;

    flash_mode_e          mode_q, mode_d;
    logic [7:0]           sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] tgtAddr_q, tgtAddr_d;
    logic [15:0]          progData_q, progData_d;
    logic [15:0]          capData_q;
    logic [ADDR_BITS-1:0] capAddr_q;
    logic                 wrActive_q;
    logic                 inReset_q;
    logic [15:0]          dout_q;

    logic                 ramWe;
    logic [ADDR_BITS-1:0] ramAddr;
    logic [15:0]          ramWdata;
    logic [15:0]          ramRdata;

    wire inReset = reset || !bus.flash_reset_b;
    wire writing = !bus.flash_ce_b && !bus.flash_we_b;
    wire fire    = wrActive_q && bus.flash_we_b;
    wire [ADDR_BITS-1:0] busAddr = bus.flash_address[ADDR_BITS:1];
    wire driveEn = !bus.flash_ce_b && !bus.flash_oe_b && bus.flash_we_b && !inReset;

    wire unusedBits = ^{bus.flash_byte_b, bus.flash_address[23:ADDR_BITS+1],
                        bus.flash_address[0]};

    // Latch the last data/address seen while a write strobe is low
    always_ff @(posedge clock) begin
        if (reset) begin
            wrActive_q <= 1'b0;
        end else begin
            wrActive_q <= writing;
        end
        if (writing) begin
            capData_q <= flash_data;
            capAddr_q <= busAddr;
        end
    end

    // Mode, status register and busy counter; device reset behaves like system reset
    always_ff @(posedge clock) begin
        inReset_q <= inReset;
        if (inReset) begin
            mode_q     <= MODE_READ_ARRAY;
            sr_q       <= SR_RESET_VALUE;
            cnt_q      <= '0;
            tgtAddr_q  <= '0;
            progData_q <= '0;
        end else begin
            mode_q     <= mode_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tgtAddr_q  <= tgtAddr_d;
            progData_q <= progData_d;
        end
    end

    // Command decode and busy sequencing; also steers the single RAM port
    always_comb begin
        mode_d     = mode_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tgtAddr_d  = tgtAddr_q;
        progData_d = progData_q;
        ramWe      = 1'b0;
        ramAddr    = busAddr;
        ramWdata   = 16'hFFFF;
        case (mode_q)
            MODE_READ_ARRAY, MODE_READ_STATUS: begin
                if (fire) begin
                    case (capData_q[7:0])
                        CMD_READ_ARRAY:  mode_d = MODE_READ_ARRAY;
                        CMD_READ_STATUS: mode_d = MODE_READ_STATUS;
                        CMD_CLEAR_STATUS: begin
                            sr_d[SR_ERASE_ERR] = 1'b0;
                            sr_d[SR_PROG_ERR]  = 1'b0;
                        end
                        CMD_PROGRAM, CMD_PROGRAM_ALT: mode_d = MODE_PROG_SETUP;
                        CMD_ERASE:       mode_d = MODE_ERASE_SETUP;
                        default: ;
                    endcase
                end
            end
            MODE_PROG_SETUP: begin
                if (fire) begin
                    tgtAddr_d      = capAddr_q;
                    progData_d     = capData_q;
                    sr_d[SR_READY] = 1'b0;
                    cnt_d          = '0;
                    mode_d         = MODE_PROG_BUSY;
                end
            end
            MODE_PROG_BUSY: begin
                ramAddr = tgtAddr_q;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PROGRAM_CYCLES - 1)) begin
                    ramWe    = 1'b1;
                    ramWdata = ramRdata & progData_q;
                    if (|(~ramRdata & progData_q)) begin
                        sr_d[SR_PROG_ERR] = 1'b1;
                    end
                    sr_d[SR_READY] = 1'b1;
                    mode_d         = MODE_READ_STATUS;
                end
            end
            MODE_ERASE_SETUP: begin
                if (fire) begin
                    if (capData_q[7:0] == CMD_CONFIRM) begin
                        tgtAddr_d      = {capAddr_q[ADDR_BITS-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};
                        sr_d[SR_READY] = 1'b0;
                        cnt_d          = '0;
                        mode_d         = MODE_ERASE_SWEEP;
                    end else begin
                        sr_d[SR_ERASE_ERR] = 1'b1;
                        sr_d[SR_PROG_ERR]  = 1'b1;
                        mode_d             = MODE_READ_STATUS;
                    end
                end
            end
            MODE_ERASE_SWEEP: begin
                ramWe   = 1'b1;
                ramAddr = {tgtAddr_q[ADDR_BITS-1:BLOCK_BITS], cnt_q[BLOCK_BITS-1:0]};
                if (cnt_q == CNT_W'((1 << BLOCK_BITS) - 1)) begin
                    cnt_d  = '0;
                    mode_d = MODE_ERASE_TAIL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MODE_ERASE_TAIL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ERASE_EXTRA_CYCLES - 1)) begin
                    sr_d[SR_READY] = 1'b1;
                    mode_d         = MODE_READ_STATUS;
                end
            end
            default: mode_d = MODE_READ_ARRAY;
        endcase
    end

    flash_emu_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clock   (clock),
        .we_i    (ramWe && !inReset),
        .addr_i  (ramAddr),
        .wdata_i (ramWdata),
        .rdata_o (ramRdata)
    );

    // Second read stage: pick array or status so data settles two clocks after the address
    always_ff @(posedge clock) begin
        dout_q <= (mode_q == MODE_READ_ARRAY) ? ramRdata : {8'h00, sr_q};
    end

    assign flash_data    = driveEn ? dout_q : 16'hzzzz;
    assign bus.flash_sts = sr_q[SR_READY] && !inReset_q;

endmodule

// File: tb/tb_flash_emu.sv
// Scoreboard bench for flash_emu: stimulus tasks queue expected values,
// a monitor pairs them with observed responses.
module tb_flash_emu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] flash_data;
    logic [15:0] hostData = 16'h0000;
    logic        hostDrive = 1'b0;

    assign flash_data = hostDrive ? hostData : 16'hzzzz;

    flash_emu_if bus();

    flash_emu #(
        .ADDR_BITS(12), .BLOCK_BITS(6), .PROGRAM_CYCLES(20), .ERASE_EXTRA_CYCLES(50)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flash_data (flash_data),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    value;
        int    tol;
    } exp_t;

    exp_t expQ[$];
    int   obsQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: pairs every observed response with the oldest queued expectation
    initial begin
        forever begin
            @(negedge clock);
            while (obsQ.size() > 0) begin
                int   obs;
                int   diff;
                exp_t e;
                obs = obsQ.pop_front();
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected: got %0h with no expectation queued", obs);
                end else begin
                    e = expQ.pop_front();
                    diff = (obs > e.value) ? obs - e.value : e.value - obs;
                    if (diff > e.tol) begin
                        miscompares++;
                        $display("[TB] FAIL %s: got %0h expected %0h (tol %0d)",
                                 e.name, obs, e.value, e.tol);
                    end
                end
            end
        end
    end

    function automatic void pushExp(input string name, input int value, input int tol);
        exp_t e;
        e.name  = name;
        e.value = value;
        e.tol   = tol;
        expQ.push_back(e);
    endfunction

    // One host write cycle; returns at the negedge just after the command fired
    task automatic applyStimulus(input int addr, input logic [15:0] data);
        @(negedge clock);
        bus.flash_address = 24'(addr * 2);
        hostData          = data;
        hostDrive         = 1'b1;
        bus.flash_ce_b    = 1'b0;
        bus.flash_we_b    = 1'b0;
        repeat (2) @(negedge clock);
        bus.flash_we_b = 1'b1;
        bus.flash_ce_b = 1'b0;
        @(negedge clock);
        bus.flash_ce_b = 1'b1;
        hostDrive      = 1'b0;
    endtask

    // One host read cycle with its expected data queued up front
    task automatic checkOutput(input string name, input int addr, input int expected);
        logic [15:0] sample;
        pushExp(name, expected, 0);
        @(negedge clock);
        bus.flash_address = 24'(addr * 2);
        bus.flash_ce_b    = 1'b0;
        bus.flash_oe_b    = 1'b0;
        repeat (3) @(negedge clock);
        sample = flash_data;
        obsQ.push_back($isunknown(sample) ? -1 : int'(sample));
        bus.flash_ce_b = 1'b1;
        bus.flash_oe_b = 1'b1;
    endtask

    task automatic expectSts(input string name, input int expected);
        pushExp(name, expected, 0);
        obsQ.push_back($isunknown(bus.flash_sts) ? -1 : int'(bus.flash_sts));
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (bus.flash_sts !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        expectSts(name, 1);
    endtask

    task automatic measureBusy(output int count);
        count = 0;
        while (bus.flash_sts === 1'b0 && count < 2000) begin
            count++;
            @(negedge clock);
        end
    endtask

    task automatic programWord(input string name, input int addr, input logic [15:0] data);
        applyStimulus(addr, 16'h0040);
        applyStimulus(addr, data);
        waitReady(name);
    endtask

    initial begin
        int busyCount;
        bus.flash_address = '0;
        bus.flash_ce_b    = 1'b1;
        bus.flash_oe_b    = 1'b1;
        bus.flash_we_b    = 1'b1;
        bus.flash_reset_b = 1'b1;
        bus.flash_byte_b  = 1'b1;

        repeat (3) @(negedge clock);
        expectSts("stsInReset", 0);
        reset = 1'b0;
        @(negedge clock);
        expectSts("stsAfterReset", 1);
        checkOutput("rdBlank5", 5, 16'hFFFF);

        applyStimulus(5, 16'h0040);
        applyStimulus(5, 16'h1234);
        fork
            measureBusy(busyCount);
            checkOutput("rdStsWhileProg", 0, 16'h0000);
        join
        pushExp("progBusyClocks", 20, 2);
        obsQ.push_back(busyCount);
        waitReady("stsProgDone");
        checkOutput("rdStsProgDone", 0, 16'h0080);
        applyStimulus(0, 16'h00FF);
        checkOutput("rdWord5First", 5, 16'h1234);

        programWord("stsProgOver", 5, 16'h00FF);
        checkOutput("rdStsProgErr", 0, 16'h0090);
        applyStimulus(0, 16'h00FF);
        checkOutput("rdWord5Anded", 5, 16'h0034);
        applyStimulus(0, 16'h0050);
        applyStimulus(0, 16'h0070);
        checkOutput("rdStsCleared", 0, 16'h0080);

        programWord("stsProg20", 20, 16'hA5A5);
        programWord("stsProg12", 12, 16'h0F0F);
        programWord("stsProg70", 70, 16'h1111);
        programWord("stsProg100", 100, 16'h2222);
        applyStimulus(0, 16'h00FF);
        checkOutput("rdWord100Pre", 100, 16'h2222);

        applyStimulus(70, 16'h0020);
        applyStimulus(70, 16'h00D0);
        measureBusy(busyCount);
        pushExp("eraseBusyClocks", 64 + 50, 2);
        obsQ.push_back(busyCount);
        waitReady("stsEraseDone");
        checkOutput("rdStsEraseDone", 0, 16'h0080);
        applyStimulus(0, 16'h00FF);
        checkOutput("rdErased64", 64, 16'hFFFF);
        checkOutput("rdErased70", 70, 16'hFFFF);
        checkOutput("rdErased100", 100, 16'hFFFF);
        checkOutput("rdErased127", 127, 16'hFFFF);
        checkOutput("rdKeep5", 5, 16'h0034);
        checkOutput("rdKeep20", 20, 16'hA5A5);

        applyStimulus(0, 16'h0020);
        applyStimulus(0, 16'h0055);
        repeat (2) @(negedge clock);
        expectSts("stsNoEraseBusy", 1);
        checkOutput("rdStsEraseErr", 0, 16'h00B0);
        applyStimulus(0, 16'h00FF);
        checkOutput("rdKeep5NoErase", 5, 16'h0034);
        checkOutput("rdKeep12NoErase", 12, 16'h0F0F);

        applyStimulus(0, 16'h0020);
        applyStimulus(3, 16'h00D0);
        repeat (10) @(negedge clock);
        bus.flash_reset_b = 1'b0;
        repeat (2) @(negedge clock);
        expectSts("stsMidReset", 0);
        bus.flash_reset_b = 1'b1;
        @(negedge clock);
        expectSts("stsAfterDevReset", 1);
        checkOutput("rdSwept0", 0, 16'hFFFF);
        checkOutput("rdSwept5", 5, 16'hFFFF);
        checkOutput("rdSwept9", 9, 16'hFFFF);
        checkOutput("rdUnswept12", 12, 16'h0F0F);
        checkOutput("rdUnswept20", 20, 16'hA5A5);
        applyStimulus(0, 16'h0070);
        checkOutput("rdStsAfterDevReset", 0, 16'h0080);

        repeat (4) @(negedge clock);
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got nothing expected %0h", e.name, e.value);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so a stuck run still ends with a diagnosis
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
